icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-line instruction cache between the IF stage and the instruction-fetch port of the memory controller. Hits return an instruction one cycle after the request. Misses issue a single 32-bit fetch to the controller, fill the line and forward the word. A flush input invalidates all lines for fence.i and for reloading the program.

## Interface
- LINES, 64: number of lines; a power of two, 2 to 1024.
- INDEX_W, log2(LINES): index width, derived.
- TAG_W, 30-INDEX_W: tag width, derived.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req_i  in  1  fetch request, sampled while cpu_stall_o=0.
- cpu_addr_i  in  32  fetch address; bits [1:0] ignored.
- cpu_stall_o  out  1  miss in progress; the IF stage holds its request.
- cpu_valid_o  out  1  one-cycle pulse; cpu_inst_o valid.
- cpu_inst_o  out  32  returned instruction.
- flush_i  in  1  invalidate all lines.
- mem_req_o  out  1  one-cycle fetch pulse to the controller if_i.
- mem_addr_o  out  32  word address of the fetch, with [1:0]=0.
- mem_busy_i  in  1  controller if_busy_o.
- mem_data_i  in  32  controller if_data_o; valid in the cycle busy falls.
- hit_cnt_o / miss_cnt_o  out  32 each; present only with ICACHE_STATS_EN.

## Operation
- Address split: tag = addr[31:INDEX_W+2]; index = addr[INDEX_W+1:2].
- Per-line storage: valid bit, tag and 32-bit data.
- **IDLE**, on cpu_req_i=1:
  - Hit (valid and tag match): cpu_valid_o<=1 and cpu_inst_o<=line data. Stay in IDLE, so back-to-back hits run at one per cycle.
  - Miss: latch the address, mem_req_o<=1, mem_addr_o<={addr[31:2],2'b00}, cpu_stall_o<=1, go to WAIT.
- **WAIT**:
  - mem_req_o<=0.
  - mem_busy_i is ignored in the first WAIT cycle (armed flag), because the controller's busy flag is registered one cycle late.
  - Once armed, mem_busy_i=0 completes the miss:
    - Write the line: valid=1, tag and data from mem_data_i.
    - cpu_inst_o<=mem_data_i, cpu_valid_o<=1, cpu_stall_o<=0, go to IDLE.
- **Flush**:
  - In IDLE: all valid bits clear at the next edge.
  - flush_i together with cpu_req_i: the flush wins and the request is looked up against the cleared array, so it is a miss.
  - During WAIT: the flush is recorded as pending. The pending flush does the following:
    - The fill still returns its data to the CPU.
    - The line is written with valid=0.
    - All valid bits clear on return to IDLE.
- cpu_req_i during WAIT is ignored; the request address is the one latched at the miss.
- **Reset**: all outputs are 0, all valid bits clear and the state is IDLE. Tag and data contents are don't-care.
- **Reset mid-miss**: the block goes to IDLE. The controller's outstanding fetch completes unobserved and its data is discarded.

## Timing
- Hit latency: 1 cycle from the request edge to cpu_valid_o.
- Miss:
  - mem_req_o is high for exactly 1 cycle, in the cycle after the miss edge.
  - cpu_valid_o comes 1 cycle after the cycle in which the controller drops busy.
  - With the current 7-step controller, total miss latency is about 9 cycles.
- cpu_stall_o rises in the cycle after the miss edge and falls together with the rise of cpu_valid_o.
- All outputs are registered; there is no combinational path from the cpu_* inputs to the mem_* outputs.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_cnt_o increments on each hit.
  - miss_cnt_o increments on each miss.
  - Both are 32-bit and wrap at 2^32. Reset clears them; flush does not.
- ICACHE_STATS_EN undefined: both ports and the counters are absent.

## Structure
- Package icache_pkg holds:
  - State enum: IDLE, WAIT.
  - Default LINES.
  - Tag and index slice helper functions.
- Sub-module icache_store holds the valid/tag/data arrays:
  - Combinational read.
  - Single write port.
  - Single-cycle clear-all.
- The FSM and the counters live in icache.

## Test plan
- **Cold miss then hit:**
  - req 0x0000_0100 with memory returning 0x0010_0093 -> one mem_req pulse at 0x100, stall high until data, then cpu_inst_o=0x0010_0093.
  - A second req 0x100 -> hit one cycle later, no mem_req.
- **Conflict:** fill 0x100, then req 0x200 with LINES=64 (same index, different tag) -> miss. Then req 0x100 -> miss again.
- **Back-to-back hits:** prefill 0x0, 0x4, 0x8; issue requests on 3 consecutive cycles -> cpu_valid_o high for 3 consecutive cycles, no stall.
- **Flush:**
  - Flush in IDLE, then req 0x100 -> miss.
  - Flush asserted during WAIT for 0x104 -> data returned, but the next req 0x104 misses.
- **Reset mid-miss:** rst low 3 cycles into WAIT -> all outputs 0. After release, req 0x100 misses and the stale controller completion produces no cpu_valid_o.
- **Stats (ICACHE_STATS_EN):** 2 misses and 5 hits -> miss_cnt_o=2 and hit_cnt_o=5. Both are unchanged by flush and cleared by reset.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and helpers for the direct-mapped instruction cache.
// Holds the FSM state enum, the default line count and the address slice helpers.
package icache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int LINES_DEF = 64;

   // Tag field, right-aligned; the caller casts it to TAG_W bits.
   function automatic logic [31:0] addr_tag(
      input logic [31:0] a,
      input int          iw
   );
      return a >> (iw + 2);
   endfunction

   // Line index field, right-aligned; the caller casts it to INDEX_W bits.
   function automatic logic [31:0] addr_idx(
      input logic [31:0] a,
      input int          iw
   );
      return (a >> 2) & ((32'd1 << iw) - 32'd1);
   endfunction

endpackage

// File: rtl/icache_store.sv
// icache_store: valid/tag/data arrays for the icache.
// Ports: rd_* combinational read, we/wr_* single write port, clr clears all valid bits.
module icache_store #(
   parameter int LINES   = 64,
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [31:0]        rd_data,
   input  logic               we,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic               wr_valid,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [31:0]        wr_data,
   input  logic               clr
);

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   // Clear-all wins over a same-edge write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (clr) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_idx] <= wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache with registered outputs.
// Ports: cpu_* fetch side, mem_* controller side, flush_i; hit/miss counters with ICACHE_STATS_EN.
module icache
   import icache_pkg::*;
#(
   parameter int LINES = LINES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req_i,
   input  logic [31:0] cpu_addr_i,
   output logic        cpu_stall_o,
   output logic        cpu_valid_o,
   output logic [31:0] cpu_inst_o,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_busy_i,
   input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
`endif
);

   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = 30 - INDEX_W;

   state_t state_q, state_d;

   logic        armed_q, armed_d;
   logic        pend_q, pend_d;
   logic        valid_q, valid_d;
   logic        stall_q, stall_d;
   logic        req_q, req_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] maddr_q, maddr_d;

   logic [INDEX_W-1:0] idx_in;
   logic [TAG_W-1:0]   tag_in;
   logic               rd_valid;
   logic [TAG_W-1:0]   rd_tag;
   logic [31:0]        rd_data;
   logic               hit;
   logic               hit_ev;
   logic               miss_ev;
   logic               fill;

   logic               we;
   logic               wr_valid;
   logic               clr;
   logic [INDEX_W-1:0] wr_idx;
   logic [TAG_W-1:0]   wr_tag;

   assign idx_in = INDEX_W'(addr_idx(cpu_addr_i, INDEX_W));
   assign tag_in = TAG_W'(addr_tag(cpu_addr_i, INDEX_W));

   // The miss address register doubles as the fill address.
   assign wr_idx = INDEX_W'(addr_idx(maddr_q, INDEX_W));
   assign wr_tag = TAG_W'(addr_tag(maddr_q, INDEX_W));

   icache_store #(
      .LINES   (LINES),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_store (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (idx_in),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .we       (we),
      .wr_idx   (wr_idx),
      .wr_valid (wr_valid),
      .wr_tag   (wr_tag),
      .wr_data  (mem_data_i),
      .clr      (clr)
   );

   // A flush in the request cycle forces a miss against the cleared array.
   assign hit     = rd_valid & (rd_tag == tag_in) & ~flush_i;
   assign hit_ev  = (state_q == IDLE) & cpu_req_i & hit;
   assign miss_ev = (state_q == IDLE) & cpu_req_i & ~hit;
   // Busy is ignored in the first WAIT cycle since the controller flags it late.
   assign fill    = (state_q == WAIT) & armed_q & ~mem_busy_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (miss_ev) state_d = WAIT;
         WAIT: if (fill) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid_d  = 1'b0;
      req_d    = 1'b0;
      inst_d   = inst_q;
      stall_d  = stall_q;
      maddr_d  = maddr_q;
      armed_d  = armed_q;
      pend_d   = pend_q;
      we       = 1'b0;
      wr_valid = 1'b0;
      clr      = 1'b0;
      unique case (state_q)
         IDLE: begin
            clr = flush_i;
            if (hit_ev) begin
               valid_d = 1'b1;
               inst_d  = rd_data;
            end else if (miss_ev) begin
               req_d   = 1'b1;
               maddr_d = {cpu_addr_i[31:2], 2'b00};
               stall_d = 1'b1;
               armed_d = 1'b0;
               pend_d  = 1'b0;
            end
         end
         WAIT: begin
            armed_d = 1'b1;
            pend_d  = pend_q | flush_i;
            if (fill) begin
               // A flush seen during the miss still returns the word
               // but leaves every line invalid.
               we       = 1'b1;
               wr_valid = ~(pend_q | flush_i);
               clr      = pend_q | flush_i;
               inst_d   = mem_data_i;
               valid_d  = 1'b1;
               stall_d  = 1'b0;
               pend_d   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed_q <= 1'b0;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         stall_q <= 1'b0;
         req_q   <= 1'b0;
         inst_q  <= '0;
         maddr_q <= '0;
      end else begin
         armed_q <= armed_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         stall_q <= stall_d;
         req_q   <= req_d;
         inst_q  <= inst_d;
         maddr_q <= maddr_d;
      end
   end

   assign cpu_valid_o = valid_q;
   assign cpu_stall_o = stall_q;
   assign cpu_inst_o  = inst_q;
   assign mem_req_o   = req_q;
   assign mem_addr_o  = maddr_q;

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_ev) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (miss_ev) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache with a 7-step controller model.
// Table-driven fetches plus hand sequences; returned words checked via a scoreboard queue.
module tb_icache;

   logic        clk;
   logic        rst;
   logic        cpu_req_i;
   logic [31:0] cpu_addr_i;
   logic        cpu_stall_o;
   logic        cpu_valid_o;
   logic [31:0] cpu_inst_o;
   logic        flush_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_busy_i;
   logic [31:0] mem_data_i;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int n_hit    = 0;
   int n_miss   = 0;
   int n_valid  = 0;

   logic [31:0] exp_q[$];

   icache #(.LINES(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_req_i   (cpu_req_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_stall_o (cpu_stall_o),
      .cpu_valid_o (cpu_valid_o),
      .cpu_inst_o  (cpu_inst_o),
      .flush_i     (flush_i),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_busy_i  (mem_busy_i),
      .mem_data_i  (mem_data_i)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0010_0093;
      return {a[15:0], 16'h0013} ^ 32'h1234_0000;
   endfunction

   // Controller model: busy shows up one cycle after the request pulse,
   // lasts 7 cycles, data valid when it falls. Not reset by rst.
   int          mcnt = 0;
   logic [31:0] maddr = '0;
   always @(posedge clk) begin
      if (mem_req_o) begin
         mcnt  <= 7;
         maddr <= mem_addr_o;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
      end
   end
   assign mem_busy_i = (mcnt != 0);
   assign mem_data_i = mem_word(maddr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every returned word must match the oldest pending fetch.
   always @(negedge clk) begin
      if (cpu_valid_o === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", cpu_inst_o, 32'hxxxx_xxxx);
         end else begin
            chk("inst_data", cpu_inst_o, exp_q.pop_front());
         end
      end
   end

   typedef struct {
      logic [31:0] addr;
      bit          pre_fl;
      bit          fl_with;
      bit          fl_mid;
      bit          hit;
      string       nm;
   } vec_t;

   vec_t tbl[14];

   task automatic fetch(input vec_t v);
      bit done;
      bit drop;
      if (v.pre_fl) begin
         @(negedge clk);
         flush_i = 1'b1;
      end
      @(negedge clk);
      cpu_req_i  = 1'b1;
      cpu_addr_i = v.addr;
      flush_i    = v.fl_with;
      exp_q.push_back(mem_word({v.addr[31:2], 2'b00}));
      @(negedge clk);
      cpu_req_i = 1'b0;
      flush_i   = 1'b0;
      if (v.hit) begin
         n_hit++;
         chk({v.nm, "_hit_flags"},
             {29'd0, cpu_valid_o, cpu_stall_o, mem_req_o}, 32'd4);
      end else begin
         n_miss++;
         chk({v.nm, "_miss_flags"},
             {29'd0, cpu_valid_o, cpu_stall_o, mem_req_o}, 32'd3);
         chk({v.nm, "_mem_addr"}, mem_addr_o, {v.addr[31:2], 2'b00});
         @(negedge clk);
         if (v.fl_mid) flush_i = 1'b1;
         chk({v.nm, "_req_pulse"}, {31'd0, mem_req_o}, 32'd0);
         done = 1'b0;
         drop = 1'b0;
         for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            flush_i = 1'b0;
            if (cpu_valid_o === 1'b1) done = 1'b1;
            else if (cpu_stall_o !== 1'b1) drop = 1'b1;
         end
         chk({v.nm, "_fill_done"}, {31'd0, done}, 32'd1);
         chk({v.nm, "_stall"}, {30'd0, drop, cpu_stall_o}, 32'd0);
      end
   endtask

   task automatic b2b();
      @(negedge clk);
      cpu_req_i  = 1'b1;
      cpu_addr_i = 32'h0;
      exp_q.push_back(mem_word(32'h0));
      @(negedge clk);
      cpu_addr_i = 32'h4;
      exp_q.push_back(mem_word(32'h4));
      chk("b2b_0", {29'd0, cpu_valid_o, cpu_stall_o, mem_req_o}, 32'd4);
      @(negedge clk);
      cpu_addr_i = 32'h8;
      exp_q.push_back(mem_word(32'h8));
      chk("b2b_1", {29'd0, cpu_valid_o, cpu_stall_o, mem_req_o}, 32'd4);
      @(negedge clk);
      cpu_req_i = 1'b0;
      chk("b2b_2", {29'd0, cpu_valid_o, cpu_stall_o, mem_req_o}, 32'd4);
      @(negedge clk);
      chk("b2b_end", {31'd0, cpu_valid_o}, 32'd0);
      n_hit += 3;
   endtask

   task automatic chk_stats(input string nm);
`ifdef ICACHE_STATS_EN
      chk({nm, "_hits"}, hit_cnt_o, n_hit);
      chk({nm, "_misses"}, miss_cnt_o, n_miss);
`else
      if (nm == "") $display("stats disabled");
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      tbl[0]  = '{32'h0000_0100, 0, 0, 0, 0, "cold"};
      tbl[1]  = '{32'h0000_0100, 0, 0, 0, 1, "rehit"};
      tbl[2]  = '{32'h0000_0200, 0, 0, 0, 0, "conflict"};
      tbl[3]  = '{32'h0000_0103, 0, 0, 0, 0, "refill"};
      tbl[4]  = '{32'h0000_0000, 0, 0, 0, 0, "pre0"};
      tbl[5]  = '{32'h0000_0004, 0, 0, 0, 0, "pre4"};
      tbl[6]  = '{32'h0000_0008, 0, 0, 0, 0, "pre8"};
      tbl[7]  = '{32'h0000_0100, 1, 0, 0, 0, "flush_idle"};
      tbl[8]  = '{32'h0000_0100, 0, 0, 0, 1, "hit_after_fl"};
      tbl[9]  = '{32'h0000_0104, 0, 0, 1, 0, "flush_wait"};
      tbl[10] = '{32'h0000_0104, 0, 0, 0, 0, "after_wfl"};
      tbl[11] = '{32'h0000_0104, 0, 0, 0, 1, "hit104"};
      tbl[12] = '{32'h0000_0104, 0, 1, 0, 0, "flush_req"};
      tbl[13] = '{32'h0000_0000, 0, 0, 0, 0, "zero_cleared"};

      rst        = 1'b0;
      cpu_req_i  = 1'b0;
      cpu_addr_i = '0;
      flush_i    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_flags", {29'd0, cpu_valid_o, cpu_stall_o, mem_req_o}, 32'd0);
      chk("rst_inst", cpu_inst_o, 32'd0);
      chk("rst_maddr", mem_addr_o, 32'd0);
      chk_stats("rst");
      rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         fetch(tbl[i]);
         if (i == 6) b2b();
      end
      chk_stats("table");

      @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      chk_stats("flush_keep");

      // Reset three cycles into a miss.
      @(negedge clk);
      cpu_req_i  = 1'b1;
      cpu_addr_i = 32'h0000_0300;
      @(negedge clk);
      cpu_req_i = 1'b0;
      chk("rmm_miss", {29'd0, cpu_valid_o, cpu_stall_o, mem_req_o}, 32'd3);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rmm_flags", {29'd0, cpu_valid_o, cpu_stall_o, mem_req_o}, 32'd0);
      chk("rmm_inst", cpu_inst_o, 32'd0);
      chk("rmm_maddr", mem_addr_o, 32'd0);
      n_hit  = 0;
      n_miss = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      v0 = n_valid;
      repeat (15) @(negedge clk);
      chk("rmm_no_valid", n_valid, v0);
      chk_stats("rmm_cleared");
      fetch('{32'h0000_0100, 0, 0, 0, 0, "post_reset"});
      chk_stats("final");

      repeat (2) @(negedge clk);
      chk("sb_drain", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
